demux1_2_reg: RTL and testbench
===============================

DEMUX1_2_REG -- requirements
Module: demux1_2_reg

Interface
REQ-001 Parameter N, default 32: payload width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream transfer request.
REQ-005 in_ready  output  1  block can accept a transfer this cycle.
REQ-006 in_sel  input  1  destination: 0 -> port 1, 1 -> port 2; same polarity as mux2_1.
REQ-007 in_data  input  N  payload.
REQ-008 out1_valid  output  1  port 1 holds a valid payload.
REQ-009 out1_ready  input  1  port 1 consumer accepts.
REQ-010 out1_data  output  N  port 1 payload.
REQ-011 out2_valid  output  1  port 2 holds a valid payload.
REQ-012 out2_ready  input  1  port 2 consumer accepts.
REQ-013 out2_data  output  N  port 2 payload.

Function
REQ-014 A transfer occurs on an edge where valid and ready are both 1; in_sel and in_data shall be sampled only on an accepted input transfer.
REQ-015 Accepted payloads shall be stored with their destination bit and presented in strict acceptance order (single FIFO, head-of-line; no reordering between ports).
REQ-016 Head entry with dest 0 shall assert out1_valid only; dest 1 shall assert out2_valid only; both valid shall never be high together.
REQ-017 The data output of the port whose valid is 1 shall carry the head payload; the other port's data shall be all zeros.
REQ-018 Latency: payload accepted at edge k shall appear on its output valid from edge k onward (visible the cycle after acceptance); no combinational in_data -> out path.
REQ-019 Head shall leave storage on the edge where its port's valid and ready are both 1; the ready of the non-selected port shall be ignored.
REQ-020 Once asserted, an output valid and its data shall stay stable until that port's transfer completes.
REQ-021 With storage empty, all output valids shall be 0; in_valid=0 shall change no state.
REQ-022 Simultaneous accept and drain in one cycle shall leave occupancy unchanged and load the new payload behind (or in place of) the drained one.
REQ-023 No transfer shall be lost or duplicated under any in_valid/outX_ready pattern.

Reset
REQ-024 rst_n low shall immediately clear occupancy, force out1_valid=out2_valid=0, out1_data=out2_data=0, in_ready=0.
REQ-025 Reset mid-operation shall discard all stored payloads; no output transfer shall complete while rst_n is low.
REQ-026 in_ready shall go to 1 on the first clk edge after rst_n rises.

Configuration
REQ-027 Macro DEMUX_SKID_EN selects storage depth.
REQ-028 Defined: 2-entry storage; in_ready shall be registered (1 when occupancy <2, independent of outX_ready in the same cycle); sustained 1 transfer/cycle with no combinational ready path.
REQ-029 Not defined: 1-entry storage; in_ready = empty OR (head draining this cycle), combinational from outX_ready; still 1 transfer/cycle when consumer is ready.
REQ-030 Port behaviour, ordering, latency and reset values shall be identical in both builds.

Verification
REQ-031 Reset then in_valid=1, in_sel=0, in_data=0xA5A5A5A5, out1_ready=1 -> next cycle out1_valid=1, out1_data=0xA5A5A5A5, out2_valid=0, out2_data=0.
REQ-032 Alternating in_sel 0,1,0,1 with data 1,2,3,4, both readys=1 -> port1 receives 1,3; port2 receives 2,4; one transfer per cycle in both builds.
REQ-033 Head dest 1 with out2_ready=0, out1_ready=1, next input sel=0 -> port1 output stays idle (head-of-line), in_ready=0 after storage fills (after 1 entry without macro, 2 with DEMUX_SKID_EN).
REQ-034 Storage full, out1_ready toggled 1/0 each cycle -> payload and valid stable while ready=0, exactly one drain per ready cycle, count of outputs equals count of inputs.
REQ-035 Two entries stored, rst_n pulsed low asynchronously mid-cycle -> outputs zero immediately, no further out transfers, in_ready=1 one edge after release.
REQ-036 Random in_valid/outX_ready/in_sel for 10000 cycles against a scoreboard -> per-port order and data match, never both valids high.

Source files
------------

// File: rtl/demux1_2_reg.sv
// demux1_2_reg: 1-to-2 demultiplexer with valid/ready handshakes and FIFO-ordered storage.
// Define DEMUX_SKID_EN for 2-entry storage with a registered in_ready; the default build uses 1 entry.
module demux1_2_reg #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sel,
  input  logic [N-1:0] in_data,
  output logic         out1_valid,
  input  logic         out1_ready,
  output logic [N-1:0] out1_data,
  output logic         out2_valid,
  input  logic         out2_ready,
  output logic [N-1:0] out2_data
);

  logic         w_head_valid;
  logic         w_head_dest;
  logic [N-1:0] w_head_data;
  logic         w_accept;
  logic         w_drain;

  // The ready of the port the head is not destined for is ignored.
  assign w_drain  = w_head_valid & (w_head_dest ? out2_ready : out1_ready);
  assign w_accept = in_valid & in_ready;

`ifdef DEMUX_SKID_EN
  logic [N:0] r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       r_in_ready;
  logic [1:0] w_count_nxt;

  // Occupancy after this cycle's accept/drain.
  always_comb begin
    w_count_nxt = r_count;
    if (w_accept && !w_drain) begin
      w_count_nxt = r_count + 2'd1;
    end else if (!w_accept && w_drain) begin
      w_count_nxt = r_count - 2'd1;
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Two-entry ring; in_ready is registered from the next occupancy so it has no path from outX_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0]   <= {(N+1){1'b0}};
      r_mem[1]   <= {(N+1){1'b0}};
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= {in_sel, in_data};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_drain) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != 2'd2);
    end
  end

  assign w_head_valid = (r_count != 2'd0);
  assign w_head_dest  = r_mem[r_rd_ptr][N];
  assign w_head_data  = r_mem[r_rd_ptr][N-1:0];
  assign in_ready     = r_in_ready;
`else
  logic         r_valid;
  logic         r_dest;
  logic [N-1:0] r_data;
  logic         r_en;

  // Single entry; r_en holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_dest  <= 1'b0;
      r_data  <= {N{1'b0}};
      r_en    <= 1'b0;
    end else begin
      r_en <= 1'b1;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_dest  <= in_sel;
        r_data  <= in_data;
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

  assign w_head_valid = r_valid;
  assign w_head_dest  = r_dest;
  assign w_head_data  = r_data;
  assign in_ready     = r_en & (~r_valid | w_drain);
`endif

  assign out1_valid = w_head_valid & ~w_head_dest;
  assign out2_valid = w_head_valid & w_head_dest;
  assign out1_data  = out1_valid ? w_head_data : {N{1'b0}};
  assign out2_data  = out2_valid ? w_head_data : {N{1'b0}};

endmodule

// File: tb/tb_demux1_2_reg.sv
// Self-checking bench for demux1_2_reg: directed vectors plus a queue-model random run.
module tb_demux1_2_reg;
  localparam int N = 32;
`ifdef DEMUX_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_sel = 1'b0;
  logic [N-1:0] in_data = '0;
  logic         out1_ready = 1'b0;
  logic         out2_ready = 1'b0;
  logic         in_ready;
  logic         out1_valid;
  logic         out2_valid;
  logic [N-1:0] out1_data;
  logic [N-1:0] out2_data;

  int n_checks = 0;
  int n_pass = 0;
  int n_in = 0;
  int n_out = 0;
  logic [N:0] q[$];
  logic m_rdy_r = 1'b0;

  demux1_2_reg #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .out2_valid(out2_valid), .out2_ready(out2_ready), .out2_data(out2_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sel, input logic [N-1:0] d,
                       input logic r1, input logic r2);
    in_valid = v; in_sel = sel; in_data = d; out1_ready = r1; out2_ready = r2;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    q.delete();
    m_rdy_r = 1'b1;
    n_in = 0;
    n_out = 0;
  endtask

  // One cycle against the reference queue: check outputs, then advance the model on the edge.
  task automatic model_step(input logic v, input logic sel, input logic [N-1:0] d,
                            input logic r1, input logic r2);
    logic hv, hd, drn, rdy, acc;
    logic [N-1:0] hdat;
    drive(v, sel, d, r1, r2);
    #1;
    hv   = (q.size() > 0);
    hd   = hv ? q[0][N] : 1'b0;
    hdat = hv ? q[0][N-1:0] : '0;
    drn  = hv && (hd ? r2 : r1);
    rdy  = (DEPTH == 1) ? (!hv || drn) : m_rdy_r;
    acc  = v && rdy;
    check_eq("m_o1_valid", 64'(out1_valid), 64'(hv && !hd));
    check_eq("m_o1_data", 64'(out1_data), (hv && !hd) ? 64'(hdat) : 64'd0);
    check_eq("m_o2_valid", 64'(out2_valid), 64'(hv && hd));
    check_eq("m_o2_data", 64'(out2_data), (hv && hd) ? 64'(hdat) : 64'd0);
    check_eq("m_in_ready", 64'(in_ready), 64'(rdy));
    check_eq("m_onehot", 64'(out1_valid && out2_valid), 64'd0);
    @(posedge clk);
    if (drn) begin
      void'(q.pop_front());
      n_out++;
    end
    if (acc) begin
      q.push_back({sel, d});
      n_in++;
    end
    m_rdy_r = (q.size() < 2);
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    check_eq("rst_o1_valid", 64'(out1_valid), 64'd0);
    check_eq("rst_o2_valid", 64'(out2_valid), 64'd0);
    check_eq("rst_o1_data", 64'(out1_data), 64'd0);
    check_eq("rst_o2_data", 64'(out2_data), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    do_reset();
    check_eq("rel_in_ready", 64'(in_ready), 64'd1);

    // Single payload to port 1
    drive(1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0);
    #1;
    check_eq("t1_in_ready", 64'(in_ready), 64'd1);
    check_eq("t1_o1_idle", 64'(out1_valid), 64'd0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    #1;
    check_eq("t1_o1_valid", 64'(out1_valid), 64'd1);
    check_eq("t1_o1_data", 64'(out1_data), 64'hA5A5A5A5);
    check_eq("t1_o2_valid", 64'(out2_valid), 64'd0);
    check_eq("t1_o2_data", 64'(out2_data), 64'd0);
    tick();
    check_eq("t1_drained", 64'(out1_valid), 64'd0);

    // Alternating destinations, one transfer per cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'(i % 2), N'(i + 1), 1'b1, 1'b1);
      #1;
      check_eq("alt_in_ready", 64'(in_ready), 64'd1);
      if (i > 0) begin
        if ((i - 1) % 2 == 0) begin
          check_eq("alt_o1_data", 64'(out1_data), 64'(i));
          check_eq("alt_o2_valid", 64'(out2_valid), 64'd0);
        end else begin
          check_eq("alt_o2_data", 64'(out2_data), 64'(i));
          check_eq("alt_o1_valid", 64'(out1_valid), 64'd0);
        end
      end
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    #1;
    check_eq("alt_last_o2", 64'(out2_data), 64'd4);
    check_eq("alt_last_o2v", 64'(out2_valid), 64'd1);
    tick();
    check_eq("alt_empty", 64'(out1_valid | out2_valid), 64'd0);

    // Head-of-line blocking
    drive(1'b1, 1'b1, 32'h22, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h33, 1'b1, 1'b0);
    #1;
    check_eq("hol_o1_idle", 64'(out1_valid), 64'd0);
    check_eq("hol_o2_data", 64'(out2_data), 64'h22);
    check_eq("hol_rdy_pre", 64'(in_ready), (DEPTH == 1) ? 64'd0 : 64'd1);
    tick();
    check_eq("hol_rdy_full", 64'(in_ready), 64'd0);
    check_eq("hol_o1_still", 64'(out1_valid), 64'd0);
    check_eq("hol_o2_hold", 64'(out2_data), 64'h22);
    drive((DEPTH == 1), 1'b0, 32'h33, 1'b1, 1'b1);
    #1;
    check_eq("hol_o2_valid", 64'(out2_valid), 64'd1);
    check_eq("hol_rdy_drain", 64'(in_ready), (DEPTH == 1) ? 64'd1 : 64'd0);
    tick();
    check_eq("hol_o1_data", 64'(out1_data), 64'h33);
    check_eq("hol_o1_valid", 64'(out1_valid), 64'd1);
    check_eq("hol_o2_gone", 64'(out2_valid), 64'd0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    tick();
    check_eq("hol_empty", 64'(out1_valid), 64'd0);
    check_eq("hol_rdy_back", 64'(in_ready), 64'd1);

    // Full storage with out1_ready toggling
    do_reset();
    for (int i = 0; i < DEPTH; i++) model_step(1'b1, 1'b0, N'(32'h80 + i), 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) model_step(1'b1, 1'b0, N'(32'h100 + k), 1'(k % 2), 1'b0);
    repeat (4) model_step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check_eq("tog_io_count", 64'(n_out), 64'(n_in));
    check_eq("tog_in_count", 64'(n_in), 64'(DEPTH + 8));

    // Asynchronous reset mid-operation
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'(i), N'(32'h55 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_o1_valid", 64'(out1_valid), 64'd0);
    check_eq("ar_o2_valid", 64'(out2_valid), 64'd0);
    check_eq("ar_o1_data", 64'(out1_data), 64'd0);
    check_eq("ar_in_ready", 64'(in_ready), 64'd0);
    repeat (2) begin
      tick();
      check_eq("ar_hold_valid", 64'(out1_valid | out2_valid), 64'd0);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("ar_rdy_low", 64'(in_ready), 64'd0);
    tick();
    check_eq("ar_rdy_high", 64'(in_ready), 64'd1);
    check_eq("ar_no_stale", 64'(out1_valid | out2_valid), 64'd0);

    // Random traffic against the queue model
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      model_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), N'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (4) model_step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check_eq("rnd_io_count", 64'(n_out), 64'(n_in));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
